// File: rtl/string_streamer_if.sv
// string_streamer_if: buffer write port, stream control and valid/ready character output.
interface string_streamer_if #(
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 7
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              loop;
    logic              abort;
    logic [CHAR_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    modport master (
        output wr_en, wr_addr, wr_data, start, len, loop, abort, out_ready,
        input  out_data, out_valid, out_last, busy, done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, loop, abort, out_ready,
        output out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/string_streamer.sv
// string_streamer: character buffer that streams a loaded string over valid/ready,
// with optional looping and abort.
module string_streamer #(
    parameter int CHAR_W = 8,
    parameter int DEPTH  = 80,
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    string_streamer_if.slave    bus
);
    localparam logic [0:0]    IDLE    = 1'b0;
    localparam logic [0:0]    STREAM  = 1'b1;
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    logic [CHAR_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic              r_loop;
    logic [CHAR_W-1:0] r_data;
    logic              r_done;
    logic [ADDR_W-1:0] w_nxt;
    logic [ADDR_W:0]   w_len;
    logic              w_last;
    logic              w_busy;
    assign w_busy = r_state == STREAM;
    assign w_nxt  = r_ptr + ADDR_W'(1);
    assign w_len  = bus.len > L_DEPTH ? L_DEPTH : bus.len;
    assign w_last = {1'b0, r_ptr} == r_len - (ADDR_W+1)'(1);
    assign bus.out_data  = r_data;
    assign bus.out_valid = w_busy;
    assign bus.out_last  = w_busy && w_last;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    // Buffer has no reset and is write-locked while streaming.
    always_ff @(posedge clk)
        if (bus.wr_en && !w_busy && {1'b0, bus.wr_addr} < L_DEPTH)
            r_mem[bus.wr_addr] <= bus.wr_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start && bus.len != '0) begin
                    r_state <= STREAM;
                    r_len   <= w_len;
                    r_loop  <= bus.loop;
                    r_ptr   <= '0;
                    r_data  <= r_mem[0];
                end else if (bus.start) begin
                    r_done <= 1'b1;
                end
            end else if (bus.abort) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
            end else if (bus.out_ready) begin
                if (!w_last) begin
                    r_ptr  <= w_nxt;
                    r_data <= r_mem[w_nxt];
                end else if (r_loop) begin
                    r_ptr  <= '0;
                    r_data <= r_mem[0];
                end else begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_string_streamer.sv
// tb_string_streamer: randomized and directed checks of string_streamer against a
// behavioural model of the buffer and the sequence of characters accepted by the sink.
module tb_string_streamer;
    localparam int CW = 8, AW = 7, DEPTH = 80;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    string_streamer_if #(.CHAR_W(CW), .ADDR_W(AW)) bus();
    string_streamer #(.CHAR_W(CW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0, bad = 0;
    logic [7:0] mem_m [DEPTH];
    bit act = 0, m_loop = 0, m_done = 0, was, d;
    int m_len = 0, k = 0;
    logic [7:0] rx [$];
    int n_busy = 0, n_last = 0, n_valid = 0, n_done = 0;
    string s = "hello, world /*";

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Model: whether a stream is active, and which character index the sink sees next.
    always @(posedge rst) begin
        act = 0; m_done = 0; k = 0;
    end
    always @(posedge clk) if (!rst) begin
        was = act;
        d = 0;
        if (!act) begin
            if (bus.start && bus.len != 0) begin
                act = 1; m_len = bus.len > DEPTH ? DEPTH : int'(bus.len); m_loop = bus.loop; k = 0;
            end else if (bus.start) d = 1;
        end else if (bus.abort) begin
            act = 0; d = 1;
        end else if (bus.out_ready) begin
            rx.push_back(mem_m[k]);
            if (k == m_len - 1) begin
                if (m_loop) k = 0;
                else begin act = 0; d = 1; end
            end else k++;
        end
        if (bus.wr_en && !was && bus.wr_addr < DEPTH) mem_m[bus.wr_addr] = bus.wr_data;
        m_done = d;
    end

    always @(negedge clk) begin
        chk("valid", bus.out_valid, act);
        chk("busy", bus.busy, act);
        chk("done", bus.done, m_done);
        chk("last", bus.out_last, act && k == m_len - 1);
        if (act) chk("data", bus.out_data, mem_m[k]);
        if (rst) chk("rst_data", bus.out_data, 0);
        n_busy += int'(bus.busy);
        n_valid += int'(bus.out_valid);
        n_done += int'(bus.done);
        n_last += int'(bus.out_valid && bus.out_ready && bus.out_last);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic clr();
        rx.delete(); n_busy = 0; n_last = 0; n_valid = 0; n_done = 0;
    endtask
    task automatic wr(int a, logic [7:0] v);
        bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = v;
        step();
        bus.wr_en = 0;
    endtask
    task automatic go(int l, bit lp);
        bus.start = 1; bus.len = (AW+1)'(l); bus.loop = lp;
        step();
        bus.start = 0;
    endtask
    task automatic wait_idle(int budget);
        int c = 0;
        while (act && c < budget) begin step(); c++; end
        if (act) begin
            total++; bad++;
            $display("FAIL timeout: still busy after %0d cycles", budget);
        end
        step();
    endtask
    task automatic chk_hello(string nm);
        chk({nm, "_n"}, rx.size(), 15);
        for (int i = 0; i < 15 && i < rx.size(); i++) chk(nm, rx[i], s[i]);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.start = 0; bus.len = 0;
        bus.loop = 0; bus.abort = 0; bus.out_ready = 0;
        step(); step();
        rst = 0;
        step();
        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
        for (int i = 0; i < 15; i++) wr(i, s[i]);
        // 1: full string, sink always ready
        clr(); bus.out_ready = 1;
        go(15, 0); wait_idle(40);
        chk_hello("t1");
        chk("t1_first", rx[0], 8'h68);
        chk("t1_lastc", rx[14], 8'h2a);
        chk("t1_busy", n_busy, 15);
        chk("t1_done", n_done, 1);
        chk("t1_nlast", n_last, 1);
        // 2: sink ready toggles every cycle
        clr(); bus.out_ready = 1;
        go(15, 0);
        for (int c = 0; c < 60 && act; c++) begin step(); bus.out_ready = ~bus.out_ready; end
        bus.out_ready = 1;
        step();
        chk_hello("t2");
        chk("t2_busy", n_busy, 29);
        // 3: loop "abc", abort on the second 'b'
        wr(0, "a"); wr(1, "b"); wr(2, "c");
        clr();
        go(3, 1);
        for (int c = 0; c < 30 && act; c++) begin bus.abort = rx.size() == 4; step(); end
        bus.abort = 0;
        step();
        chk("t3_n", rx.size(), 4);
        chk("t3_c3", rx[3], 8'h61);
        chk("t3_c2", rx[2], 8'h63);
        chk("t3_nlast", n_last, 1);
        chk("t3_done", n_done, 1);
        // 4: zero length, then oversize length clipped to depth
        clr(); go(0, 0); step();
        chk("t4_valid", n_valid, 0);
        chk("t4_done", n_done, 1);
        clr(); go(200, 0); wait_idle(200);
        chk("t4_n", rx.size(), 80);
        chk("t4_busy", n_busy, 80);
        // 5: start and write during a stream are ignored; out-of-range write dropped
        for (int i = 0; i < 15; i++) wr(i, s[i]);
        clr(); go(15, 0); step(); step();
        bus.start = 1; bus.len = 3; bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 0;
        step();
        bus.start = 0; bus.wr_en = 0;
        wait_idle(40);
        chk("t5_n", rx.size(), 15);
        wr(90, 8'h55);
        clr(); go(15, 0); wait_idle(40);
        chk_hello("t5");
        chk("t5_first", rx[0], 8'h68);
        // 6: async reset mid-stream, then restart
        clr(); go(15, 0);
        for (int i = 0; i < 5; i++) step();
        chk("t6_sent", rx.size(), 5);
        rst = 1; #2;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_last", bus.out_last, 0);
        chk("t6_data", bus.out_data, 0);
        step(); rst = 0; step();
        chk("t6_done", n_done, 0);
        clr(); go(15, 0); wait_idle(40);
        chk_hello("t6");
        // random traffic
        for (int c = 0; c < 800; c++) begin
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.abort = $urandom_range(0, 40) == 0;
            bus.start = $urandom_range(0, 6) == 0;
            bus.len = $urandom_range(0, 9) == 0 ? '0 : (AW+1)'($urandom_range(1, 100));
            bus.loop = $urandom_range(0, 3) == 0;
            bus.wr_en = !bus.start && $urandom_range(0, 2) == 0;
            bus.wr_addr = AW'($urandom_range(0, 100));
            bus.wr_data = 8'($urandom);
            step();
        end
        bus.start = 0; bus.wr_en = 0; bus.abort = 1;
        step();
        bus.abort = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
